// File: rtl/range_pkg.sv
// Shared types and defaults for the range scan controller and its accumulator.
package range_pkg;

  localparam int RANGE_SIZE_DEF = 256;
  localparam int ADDR_BITS_DEF  = 8;
  localparam int SUM_W          = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SCAN   = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_RESULT = 3'd5
  } state_e;

endpackage

// File: rtl/scan_accum.sv
// Running max (first index wins ties) and sum over the counts consumed during a scan.
module scan_accum
  import range_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 valid,
  input  logic [ADDR_BITS-1:0] index,
  input  logic [15:0]          count,
  input  logic [31:0]          base_n,
  output logic [15:0]          max_count,
  output logic [31:0]          max_n,
  output logic [SUM_W-1:0]     sum_count
);

  logic [31:0] index_ext;
  assign index_ext = {{(32-ADDR_BITS){1'b0}}, index};

  always_ff @(posedge clk) begin
    if (clear) begin
      max_count <= '0;
      max_n     <= '0;
      sum_count <= '0;
    end else if (valid) begin
      // Index 0 seeds the tracker even for a zero count; strict > keeps the lowest index on ties.
      if (index == '0 || count > max_count) begin
        max_count <= count;
        max_n     <= base_n + index_ext;
      end
      sum_count <= sum_count + {{(SUM_W-16){1'b0}}, count};
    end
  end

endmodule

// File: rtl/range_scan_ctrl.sv
// Launches a range run, waits for completion, then scans the result RAM once into scan_accum.
module range_scan_ctrl
  import range_pkg::*;
#(
  parameter int RANGE_SIZE = RANGE_SIZE_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic [31:0]       base_n,
  output logic              go,
  output logic [31:0]       start,
  input  logic              done,
  input  logic [15:0]       count,
  output logic              busy,
  output logic              result_valid,
  output logic [15:0]       max_count,
  output logic [31:0]       max_n,
  output logic [SUM_W-1:0]  sum_count,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] LAUNCH = ST_LAUNCH;
  localparam logic [2:0] WAIT   = ST_WAIT;
  localparam logic [2:0] SCAN   = ST_SCAN;
  localparam logic [2:0] FLUSH  = ST_FLUSH;
  localparam logic [2:0] RESULT = ST_RESULT;

  localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(RANGE_SIZE - 1);

  logic [2:0]           state;
  logic [ADDR_BITS-1:0] addr;
  logic [31:0]          base_q;
  logic                 wait_first;
  logic                 start_ok;
  logic                 accum_clear;
  logic                 accum_valid;
  logic [ADDR_BITS-1:0] accum_index;

  // Command handshake: cmd_start is a one-cycle request, taken only when the block is
  // not busy (IDLE or RESULT) and cmd_abort is low that cycle; otherwise it is dropped.
  assign start_ok = cmd_start && !cmd_abort && (state == IDLE || state == RESULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      base_q       <= '0;
      wait_first   <= 1'b0;
      result_valid <= 1'b0;
    end else if (cmd_abort) begin
      state        <= IDLE;
      addr         <= '0;
      wait_first   <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, RESULT: begin
          if (cmd_start) begin
            base_q       <= base_n;
            result_valid <= 1'b0;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          wait_first <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          // The first WAIT cycle masks done so a level left over from the last run is not taken.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (done) begin
            addr  <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          addr <= addr + ADDR_BITS'(1);
          if (addr == ADDR_LAST) state <= FLUSH;
        end
        FLUSH: begin
          result_valid <= 1'b1;
          state        <= RESULT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM data lags the address by one cycle; addr wraps to 0 in FLUSH so addr-1 names the last word.
  assign accum_clear = reset || start_ok;
  assign accum_valid = (state == SCAN && addr != '0) || state == FLUSH;
  assign accum_index = addr - ADDR_BITS'(1);

  scan_accum #(.ADDR_BITS(ADDR_BITS)) u_accum (
    .clk       (clk),
    .clear     (accum_clear),
    .valid     (accum_valid),
    .index     (accum_index),
    .count     (count),
    .base_n    (base_q),
    .max_count (max_count),
    .max_n     (max_n),
    .sum_count (sum_count)
  );

  always_comb begin
    start = '0;
    case (state)
      LAUNCH, WAIT: start = base_q;
      SCAN:         start = {{(32-ADDR_BITS){1'b0}}, addr};
      default:      start = '0;
    endcase
  end

  assign go        = (state == LAUNCH);
  assign busy      = !(state == IDLE || state == RESULT);
  assign dbg_state = state;

endmodule

// File: tb/tb_range_scan_ctrl.sv
// Randomized scoreboard bench for range_scan_ctrl with a behavioural range datapath and RAM.
module tb_range_scan_ctrl;
  import range_pkg::*;

  localparam int RS       = 256;
  localparam int AB       = 8;
  localparam int DONE_LAT = 50;

  logic        clk = 1'b0;
  logic        reset, cmd_start, cmd_abort, done;
  logic [31:0] base_n;
  logic [15:0] count;
  logic        go, busy, result_valid;
  logic [31:0] start, max_n;
  logic [15:0] max_count;
  logic [23:0] sum_count;
  logic [2:0]  dbg_state;

  range_scan_ctrl #(.RANGE_SIZE(RS), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .base_n(base_n), .go(go), .start(start), .done(done), .count(count),
    .busy(busy), .result_valid(result_valid), .max_count(max_count),
    .max_n(max_n), .sum_count(sum_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [71:0] exp_q[$];
  logic [15:0] mem [RS];
  int stale_hold = 0;
  int done_rise_cyc = 0;
  int go_cnt = 0;
  int scan_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected result straight from the rules: seed at index 0, strict > afterwards, plain sum.
  function automatic logic [71:0] model(input logic [31:0] b);
    logic [15:0] mc;
    logic [31:0] mn;
    logic [23:0] sc;
    mc = 0; mn = 0; sc = 0;
    for (int i = 0; i < RS; i++) begin
      if (i == 0 || mem[i] > mc) begin
        mc = mem[i];
        mn = b + 32'(i);
      end
      sc = sc + 24'(mem[i]);
    end
    return {mc, mn, sc};
  endfunction

  // ---------------- behavioural range datapath and RAM ----------------
  logic [31:0] addr_lat = 0;
  initial begin
    count = 0;
    forever begin
      @(negedge clk) addr_lat = start;
      @(posedge clk); #1;
      count = mem[addr_lat[AB-1:0]];
    end
  end

  initial begin
    done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (go) begin
        for (int k = 0; k < stale_hold; k++) begin
          @(posedge clk); #1;
        end
        done = 1'b0;
        for (int k = stale_hold; k < DONE_LAT; k++) @(posedge clk);
        #1;
        done = 1'b1;
        done_rise_cyc = cyc;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [2:0] prev_state = 3'd0;
  logic       prev_rv = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (go) go_cnt++;
      if (dbg_state == ST_SCAN && prev_state != ST_SCAN) begin
        scan_cyc = cyc;
        chk("scan_entry_after_done", 32'(cyc), 32'(done_rise_cyc + 1));
      end
      if (result_valid && !prev_rv) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got result with max_n %0h, expected none", max_n);
        end else begin
          logic [71:0] e;
          e = exp_q.pop_front();
          chk("max_count", 32'(max_count), 32'(e[71:56]));
          chk("max_n", max_n, e[55:24]);
          chk("sum_count", 32'(sum_count), 32'(e[23:0]));
          chk("scan_latency", 32'(cyc - scan_cyc), 32'(RS + 1));
          chk("go_pulses", 32'(go_cnt), 32'd1);
        end
      end
    end
    prev_state = dbg_state;
    prev_rv    = result_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input logic [31:0] b);
    exp_q.push_back(model(b));
    @(negedge clk);
    go_cnt    = 0;
    base_n    = b;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    base_n    = $urandom;
  endtask

  task automatic wait_result();
    int k;
    k = 0;
    while (!result_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!result_valid) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: got result_valid 0, expected 1 within 2000 cycles");
    end
  endtask

  task automatic wait_scan_index(input int idx);
    int k;
    k = 0;
    while (!(dbg_state == ST_SCAN && start == 32'(idx)) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) begin
      checks++;
      failures++;
      $display("FAIL scan_index_timeout: got no scan index %0d, expected it within 2000 cycles", idx);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_go"}, 32'(go), 32'd0);
    chk({tag, "_start"}, start, 32'd0);
    chk({tag, "_max_count"}, 32'(max_count), 32'd0);
    chk({tag, "_max_n"}, max_n, 32'd0);
    chk({tag, "_sum_count"}, 32'(sum_count), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; base_n = 0;
    for (int i = 0; i < RS; i++) mem[i] = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Ramp: count[i] = i, base 1000, with an ignored cmd_start mid-scan.
    for (int i = 0; i < RS; i++) mem[i] = 16'(i);
    issue_start(32'd1000);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_scan_index(50);
    base_n = 32'd77; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    wait_result();
    chk("ramp_max_count", 32'(max_count), 32'd255);
    chk("ramp_max_n", max_n, 32'd1255);
    chk("ramp_sum", 32'(sum_count), 32'd32640);
    repeat (5) @(negedge clk);
    chk("hold_result_valid", 32'(result_valid), 32'd1);
    chk("hold_max_n", max_n, 32'd1255);
    chk("hold_busy", 32'(busy), 32'd0);

    // Ties with done left high from the previous run held through LAUNCH and the first WAIT.
    for (int i = 0; i < RS; i++) mem[i] = 16'd7;
    stale_hold = 2;
    issue_start(32'd5);
    wait_result();
    stale_hold = 0;
    chk("tie_max_count", 32'(max_count), 32'd7);
    chk("tie_max_n", max_n, 32'd5);
    chk("tie_sum", 32'(sum_count), 32'd1792);

    // Wrap of base_n + index past 2^32.
    for (int i = 0; i < RS; i++) mem[i] = 16'($urandom_range(0, 899));
    mem[32] = 16'd900;
    issue_start(32'hFFFF_FFF0);
    wait_result();
    chk("wrap_max_n", max_n, 32'h0000_0010);

    // Back-to-back start from RESULT: result drops and accumulators clear.
    for (int i = 0; i < RS; i++) mem[i] = 16'($urandom_range(0, 65535));
    issue_start(32'd2000);
    chk("b2b_result_valid", 32'(result_valid), 32'd0);
    chk("b2b_sum_cleared", 32'(sum_count), 32'd0);
    chk("b2b_max_cleared", 32'(max_count), 32'd0);
    wait_result();

    // All-zero counts still seed max_n from index 0.
    for (int i = 0; i < RS; i++) mem[i] = 16'd0;
    issue_start(32'd42);
    wait_result();

    // Abort at index 100 together with a cmd_start that must be ignored.
    for (int i = 0; i < RS; i++) mem[i] = 16'($urandom_range(0, 65535));
    issue_start($urandom);
    wait_scan_index(100);
    void'(exp_q.pop_back());
    cmd_abort = 1'b1; cmd_start = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0; cmd_start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result_valid", 32'(result_valid), 32'd0);
    chk("abort_go", 32'(go), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // Reset at index 200.
    issue_start($urandom);
    wait_scan_index(200);
    void'(exp_q.pop_back());
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midscan_reset");
    reset = 1'b0;
    @(negedge clk);

    // Random runs, some with a stale done.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < RS; i++) mem[i] = 16'($urandom_range(0, 65535));
      stale_hold = 2 * $urandom_range(0, 1);
      issue_start($urandom);
      wait_result();
    end
    stale_hold = 0;

    repeat (5) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
